// File: rtl/spart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : spart_rx_if
//  Description : Signal bundle between the SPART receiver and its neighbours.
//                It carries the serial line, the 16x baud tick, the consumer
//                read strobe and the received-byte/status outputs.
//
//                Modports:
//                  slave  - the receiver (spart_rx)
//                  master - line driver / baud source / byte consumer
//
//                Signals:
//                  rxd        serial line, idles high (asynchronous)
//                  rx_baud_en one-clk tick at 16x the bit rate
//                  rd_en      one-clk consumer read strobe
//                  rx_data    last received byte
//                  rda        receive data available
//                  overrun    unread byte was overwritten (sticky)
//                  frame_err  stop bit sampled low (sticky)
//  Revision    : 1.0 - initial release
// ============================================================================
interface spart_rx_if;
  logic       rxd;
  logic       rx_baud_en;
  logic       rd_en;
  logic [7:0] rx_data;
  logic       rda;
  logic       overrun;
  logic       frame_err;

  modport slave (
    input  rxd,
    input  rx_baud_en,
    input  rd_en,
    output rx_data,
    output rda,
    output overrun,
    output frame_err
  );

  modport master (
    output rxd,
    output rx_baud_en,
    output rd_en,
    input  rx_data,
    input  rda,
    input  overrun,
    input  frame_err
  );
endinterface
`default_nettype wire

// File: rtl/spart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spart_rx
//  Description : 8N1 serial receiver with 16x oversampling. The line is
//                synchronized through two flops, a start bit is qualified at
//                its middle, then each data bit and the stop bit are sampled
//                16 ticks apart. A completed byte is latched into rx_data and
//                flagged with rda; overwriting an unread byte sets overrun.
//
//  Ports       : clk  - single clock for all logic
//                rst  - synchronous active-high reset
//                bus  - spart_rx_if.slave (rxd, rx_baud_en, rd_en in;
//                       rx_data, rda, overrun, frame_err out)
//
//  Options     : SPART_RX_FRAMING_ERR_EN
//                  defined   - a low stop bit sets frame_err and the byte is
//                              discarded (rx_data/rda untouched)
//                  undefined - frame_err is tied low and the byte is
//                              delivered regardless of the stop bit level
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_rx (
  input  wire logic clk,
  input  wire logic rst,
  spart_rx_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  // Tick count value at which the start bit is checked (its 8th tick, i.e.
  // the middle of the bit) and at which data/stop bits are sampled (16th).
  localparam logic [3:0] c_MID_TICK  = 4'd7;
  localparam logic [3:0] c_LAST_TICK = 4'd15;
  localparam logic [2:0] c_LAST_BIT  = 3'd7;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic       r_rxd_meta;
  logic       r_rxd_sync;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;

  logic [3:0] r_tick_cnt;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;

  logic       w_cnt_clr;   // restart the bit timing (tick and bit index)
  logic       w_shift_en;  // sample one data bit into the shift register
  logic       w_stop_smp;  // the stop bit is being sampled on this edge
  logic       w_load;      // deliver the shift register to rx_data

  logic [7:0] r_rx_data;
  logic       r_rda;
  logic       r_overrun;

  // --------------------------------------------------------------------------
  // Input synchronizer. Both flops reset high so that reset never looks like
  // a falling start edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= bus.rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Nothing moves between baud ticks.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (bus.rx_baud_en) begin
      case (r_state)
        c_IDLE: begin
          if (!r_rxd_sync) begin
            w_state_nxt = c_START;
          end
        end
        c_START: begin
          // A line that is back high by mid start bit was a glitch.
          if (r_tick_cnt == c_MID_TICK) begin
            w_state_nxt = r_rxd_sync ? c_IDLE : c_DATA;
          end
        end
        c_DATA: begin
          if ((r_tick_cnt == c_LAST_TICK) && (r_bit_idx == c_LAST_BIT)) begin
            w_state_nxt = c_STOP;
          end
        end
        c_STOP: begin
          // Return straight to IDLE on the sample edge; a low line seen
          // while still in STOP is never treated as a start.
          if (r_tick_cnt == c_LAST_TICK) begin
            w_state_nxt = c_IDLE;
          end
        end
        default: begin
          w_state_nxt = c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (datapath strobes)
  // --------------------------------------------------------------------------
  always_comb begin
    w_cnt_clr  = 1'b0;
    w_shift_en = 1'b0;
    w_stop_smp = 1'b0;
    if (bus.rx_baud_en) begin
      case (r_state)
        c_IDLE: begin
          // Holding the counters at zero in IDLE means START always begins
          // its count from a clean value.
          w_cnt_clr = 1'b1;
        end
        c_START: begin
          if (r_tick_cnt == c_MID_TICK) begin
            w_cnt_clr = 1'b1;
          end
        end
        c_DATA: begin
          if (r_tick_cnt == c_LAST_TICK) begin
            w_shift_en = 1'b1;
          end
        end
        c_STOP: begin
          if (r_tick_cnt == c_LAST_TICK) begin
            w_stop_smp = 1'b1;
          end
        end
        default: begin
          w_cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bit timing counters and shift register. Both counters wrap naturally:
  // the tick counter rolls 15->0 between bits and the bit index rolls 7->0
  // as the last data bit is taken.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
    end else if (bus.rx_baud_en) begin
      if (w_cnt_clr) begin
        r_tick_cnt <= 4'd0;
        r_bit_idx  <= 3'd0;
      end else begin
        r_tick_cnt <= r_tick_cnt + 4'd1;
      end
      if (w_shift_en) begin
        // LSB arrives first, so shift in from the top.
        r_shift   <= {r_rxd_sync, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stop-bit qualification
  // --------------------------------------------------------------------------
`ifdef SPART_RX_FRAMING_ERR_EN
  logic w_frame_set;
  logic r_frame_err;

  assign w_load      = w_stop_smp &  r_rxd_sync;
  assign w_frame_set = w_stop_smp & ~r_rxd_sync;

  // A framing error has priority over a same-edge read so the event is
  // never lost; a read on any other edge clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else if (w_frame_set) begin
      r_frame_err <= 1'b1;
    end else if (bus.rd_en) begin
      r_frame_err <= 1'b0;
    end
  end

  assign bus.frame_err = r_frame_err;
`else
  // Without framing checks the stop bit level is ignored.
  assign w_load        = w_stop_smp;
  assign bus.frame_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Receive buffer and status. A load beats a coincident read: the new byte
  // stays available, and since the consumer just read the old one the
  // overwrite is not an overrun (the read also clears any older overrun).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data <= 8'h00;
      r_rda     <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_load) begin
      r_rx_data <= r_shift;
      r_rda     <= 1'b1;
      r_overrun <= bus.rd_en ? 1'b0 : (r_overrun | r_rda);
    end else if (bus.rd_en) begin
      r_rda     <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign bus.rx_data = r_rx_data;
  assign bus.rda     = r_rda;
  assign bus.overrun = r_overrun;

endmodule
`default_nettype wire

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 SHALL provide clk, input, 1, the single clock for all logic.
REQ-002 SHALL provide rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL provide rxd, input, 1, asynchronous serial line; idles high.
REQ-004 SHALL provide rx_baud_en, input, 1, one-clk tick at 16x the bit rate, from the baud generator.
REQ-005 SHALL provide rd_en, input, 1, one-clk consumer read strobe.
REQ-006 SHALL provide rx_data, output, 8, last received byte.
REQ-007 SHALL provide rda, output, 1, receive data available.
REQ-008 SHALL provide overrun, output, 1, unread byte was overwritten (sticky).
REQ-009 SHALL provide frame_err, output, 1, stop bit sampled low (sticky; 0 unless macro defined).

Function
REQ-010 SHALL pass rxd through a 2-flop synchronizer; both flops reset to 1; all sampling uses the synchronized value.
REQ-011 SHALL advance the oversample counter and FSM only on clk edges where rx_baud_en=1; otherwise hold state.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; reset state is IDLE.
REQ-013 IDLE: on a tick with synchronized rxd=0 -> START, clear tick counter.
REQ-014 START: on the 8th tick (mid start bit) sample; 0 -> DATA with counter cleared; 1 -> IDLE (false start, no flags).
REQ-015 DATA: sample on every 16th tick; shift LSB first into 8-bit shift register; after bit 7 -> STOP.
REQ-016 STOP: sample on the 16th tick, then -> IDLE in the same edge.
REQ-017 Valid stop (1): SHALL load rx_data from the shift register and set rda=1 on that edge (visible next cycle).
REQ-018 If rda=1 and rd_en=0 at load: SHALL overwrite rx_data and set overrun=1.
REQ-019 rd_en=1 with no load on the same edge: SHALL clear rda, overrun and frame_err.
REQ-020 rd_en=1 coincident with a load: load wins; rda stays 1; overrun not set; overrun/frame_err cleared.
REQ-021 rd_en with rda=0 SHALL have no effect except clearing the sticky flags.
REQ-022 Counters SHALL be 4-bit tick and 3-bit bit-index; wrap modulo width, no saturation.
REQ-023 A new start edge is accepted only from IDLE; low rxd during STOP processing is not a start.

Reset
REQ-024 rst=1 SHALL force IDLE, counters 0, shift register 0x00, rx_data 0x00, rda 0, overrun 0, frame_err 0, synchronizer 1/1.
REQ-025 rst mid-frame SHALL abort the frame with no rda/flag change after release; reception restarts at the next start edge.

Configuration
REQ-026 Macro SPART_RX_FRAMING_ERR_EN defined: stop bit 0 SHALL set frame_err=1, leave rx_data and rda unchanged.
REQ-027 Macro undefined: frame_err SHALL be tied 0; stop bit 0 SHALL deliver the byte exactly as a valid stop (REQ-017/018).

Verification
REQ-028 rx_baud_en every 4 clks; send 0xA5 8N1 -> rda=1, rx_data=0xA5, overrun=0, frame_err=0.
REQ-029 rxd low for 4 ticks then high -> FSM returns to IDLE; rda stays 0.
REQ-030 Send 0x3C then 0xC3, no rd_en -> rx_data=0xC3, rda=1, overrun=1; rd_en pulse -> rda=0, overrun=0.
REQ-031 Send 0x55 with stop bit 0 -> macro defined: frame_err=1, rda=0; macro undefined: rda=1, rx_data=0x55.
REQ-032 Assert rst during DATA bit 3 of 0xFF, release, send 0x12 -> only 0x12 delivered; rx_data=0x12.
REQ-033 rd_en on the exact load edge of a second byte 0x81 -> rda=1, rx_data=0x81, overrun=0.
